// File: rtl/mult_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mult_rr_arbiter
//   Shares one combinational 8x8 unsigned multiplier among NUM_REQ requesters.
//   A round-robin grant picks one valid requester per cycle. Its operands are
//   multiplied and the 16-bit product is captured in a single response
//   register, tagged with the requester index.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst_n      - synchronous active-low reset
//   req_valid  - per-requester request valid            [NUM_REQ]
//   req_ready  - per-requester accept, one-hot or zero  [NUM_REQ]
//   req_in1    - packed multiplicands, 8 bits each      [8*NUM_REQ]
//   req_in2    - packed multipliers, 8 bits each        [8*NUM_REQ]
//   resp_valid - response register holds a product
//   resp_ready - consumer accepts the response
//   resp_id    - requester index of the response        [ID_W]
//   resp_data  - unsigned product in1*in2               [16]
//   busy       - response register occupied (same as resp_valid)
// ----------------------------------------------------------------------------
module mult_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [8*NUM_REQ-1:0]   req_in1,
    input  logic [8*NUM_REQ-1:0]   req_in2,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [15:0]            resp_data,
    output logic                   busy
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]      state_r;
    logic [ID_W-1:0] rr_ptr_r;
    logic [ID_W-1:0] resp_id_r;
    logic [15:0]     resp_data_r;

    logic            resp_valid_s;
    logic            can_accept_s;
    logic            grant_found_s;
    logic [ID_W-1:0] grant_idx_s;
    logic            hi_found_s;
    logic [ID_W-1:0] hi_idx_s;
    logic [ID_W-1:0] any_idx_s;
    logic            accept_s;
    logic [7:0]      in1_s;
    logic [7:0]      in2_s;
    logic [15:0]     product_s;
    logic [ID_W-1:0] next_ptr_s;

    assign resp_valid_s = (state_r == ST_FULL);
    // A drain in the same cycle frees the register, giving one product per cycle.
    assign can_accept_s = !resp_valid_s || resp_ready;

    // Round-robin search: the lowest valid index at or above rr_ptr wins;
    // if none exists the search wraps and the lowest valid index overall wins.
    // Scanning downward lets the last hit be the lowest index.
    always_comb begin
        grant_found_s = 1'b0;
        hi_found_s    = 1'b0;
        hi_idx_s      = {ID_W{1'b0}};
        any_idx_s     = {ID_W{1'b0}};
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_found_s = 1'b1;
                any_idx_s     = ID_W'(i);
                if (i >= int'(rr_ptr_r)) begin
                    hi_found_s = 1'b1;
                    hi_idx_s   = ID_W'(i);
                end else begin
                    hi_found_s = hi_found_s;
                end
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        if (hi_found_s) begin
            grant_idx_s = hi_idx_s;
        end else begin
            grant_idx_s = any_idx_s;
        end
    end

    // Operand mux: route the granted requester's operands to the multiplier.
    always_comb begin
        in1_s = 8'h00;
        in2_s = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == grant_idx_s) begin
                in1_s = req_in1[i*8 +: 8];
                in2_s = req_in2[i*8 +: 8];
            end else begin
                in1_s = in1_s;
            end
        end
    end

    assign product_s = {8'h00, in1_s} * {8'h00, in2_s};
    assign accept_s  = rst_n && grant_found_s && can_accept_s;

    // Ready goes only to the granted requester, and never while in reset.
    always_comb begin
        req_ready = {NUM_REQ{1'b0}};
        if (accept_s) begin
            req_ready[grant_idx_s] = 1'b1;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    // Pointer moves to the requester just after the winner, wrapping at NUM_REQ.
    always_comb begin
        if (grant_idx_s == ID_W'(NUM_REQ - 1)) begin
            next_ptr_s = {ID_W{1'b0}};
        end else begin
            next_ptr_s = grant_idx_s + ID_W'(1'b1);
        end
    end

    // Response register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            rr_ptr_r    <= {ID_W{1'b0}};
            resp_id_r   <= {ID_W{1'b0}};
            resp_data_r <= 16'h0000;
        end else begin
            case (state_r)
                ST_EMPTY, ST_FULL: begin
                    if (accept_s) begin
                        state_r     <= ST_FULL;
                        rr_ptr_r    <= next_ptr_s;
                        resp_id_r   <= grant_idx_s;
                        resp_data_r <= product_s;
                    end else if (resp_valid_s && resp_ready) begin
                        // Drain only: id and data keep their last values.
                        state_r <= ST_EMPTY;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                end
            endcase
        end
    end

    assign resp_valid = resp_valid_s;
    assign busy       = resp_valid_s;
    assign resp_id    = resp_id_r;
    assign resp_data  = resp_data_r;

endmodule

// File: tb/tb_mult_rr_arbiter.sv
module tb_mult_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_in1;
    logic [31:0] req_in2;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_id;
    logic [15:0] resp_data;
    logic        busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] data;
    } exp_t;

    exp_t q[$];
    int   m_ptr  = 0;
    logic m_full = 1'b0;

    mult_rr_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_in1    (req_in1),
        .req_in2    (req_in2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        req_in1[i*8 +: 8] = a;
        req_in2[i*8 +: 8] = b;
    endtask

    // One clock cycle: inputs already driven just after the previous edge.
    // Checks the grant against the model, scoreboards accepts, and checks
    // the response state after the edge.
    task automatic tick();
        int         g;
        logic       found;
        logic       can;
        logic [3:0] exp_ready;
        exp_t       e;
        #1;
        found = 1'b0;
        g     = 0;
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (m_ptr + k) % 4;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
        can       = !m_full || resp_ready;
        exp_ready = 4'b0000;
        if (rst_n && found && can) exp_ready[g] = 1'b1;
        chk("req_ready", {28'h0, req_ready}, {28'h0, exp_ready});
        if (m_full && q.size() > 0) begin
            chk("resp_id", {30'h0, resp_id}, {30'h0, q[0].id});
            chk("resp_data", {16'h0, resp_data}, {16'h0, q[0].data});
        end
        if (!rst_n) begin
            q.delete();
            m_full = 1'b0;
            m_ptr  = 0;
        end else begin
            if (m_full && resp_ready && q.size() > 0) void'(q.pop_front());
            if (exp_ready != 4'b0000) begin
                e.id   = 2'(g);
                e.data = {8'h00, req_in1[g*8 +: 8]} * {8'h00, req_in2[g*8 +: 8]};
                q.push_back(e);
                m_full = 1'b1;
                m_ptr  = (g + 1) % 4;
            end else if (m_full && resp_ready) begin
                m_full = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("resp_valid", {31'h0, resp_valid}, {31'h0, m_full});
        chk("busy", {31'h0, busy}, {31'h0, m_full});
    endtask

    initial begin
        // Reset held two cycles with every requester valid
        rst_n      = 1'b0;
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_op(i, 8'(i + 1), 8'd10);
        tick();
        tick();
        chk("rst_data", {16'h0, resp_data}, 32'h0);
        chk("rst_id", {30'h0, resp_id}, 32'h0);

        // Round robin, all valid: ids 0,1,2,3,0 with data 10,20,30,40,10
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_id", {30'h0, resp_id}, 32'(k % 4));
            chk("rr_data", {16'h0, resp_data}, 32'(10 * ((k % 4) + 1)));
        end
        req_valid = 4'b0000;
        tick();

        // Single request on requester 2: 13*11 = 143
        req_valid = 4'b0100;
        set_op(2, 8'd13, 8'd11);
        tick();
        chk("single_id", {30'h0, resp_id}, 32'd2);
        chk("single_data", {16'h0, resp_data}, 32'd143);
        req_valid = 4'b0000;
        tick();

        // Back-pressure: response held 3 cycles while req 1 and 3 wait
        req_valid = 4'b0001;
        set_op(0, 8'd7, 8'd9);
        tick();
        chk("bp_first", {16'h0, resp_data}, 32'd63);
        req_valid  = 4'b1010;
        resp_ready = 1'b0;
        set_op(1, 8'd12, 8'd12);
        set_op(3, 8'd5, 8'd5);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_data", {16'h0, resp_data}, 32'd63);
            chk("bp_hold_id", {30'h0, resp_id}, 32'd0);
        end
        resp_ready = 1'b1;
        tick();
        chk("bp_next_id", {30'h0, resp_id}, 32'd1);
        chk("bp_next_data", {16'h0, resp_data}, 32'd144);
        req_valid = 4'b0000;
        tick();

        // Width extremes, back-to-back on requester 2
        req_valid = 4'b0100;
        set_op(2, 8'hFF, 8'hFF);
        tick();
        chk("ext_ffff", {16'h0, resp_data}, 32'h0000FE01);
        set_op(2, 8'h80, 8'h02);
        tick();
        chk("ext_8002", {16'h0, resp_data}, 32'h00000100);
        set_op(2, 8'h00, 8'hFF);
        tick();
        chk("ext_00ff", {16'h0, resp_data}, 32'h00000000);
        req_valid = 4'b0000;
        tick();

        // Reset mid-operation: pending response discarded, pointer back to 0
        req_valid = 4'b0100;
        set_op(2, 8'd3, 8'd3);
        tick();
        req_valid  = 4'b0000;
        resp_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_valid", {31'h0, resp_valid}, 32'h0);
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        req_valid  = 4'b1010;
        tick();
        chk("midrst_id", {30'h0, resp_id}, 32'd1);
        chk("midrst_data", {16'h0, resp_data}, 32'd144);
        req_valid = 4'b0000;
        tick();
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_rr_arbiter.md
Name: mult_rr_arbiter

Overview:
- Shares one combinational 8x8 unsigned multiplier datapath among NUM_REQ requesters.
- Arbitration is round-robin; each requester has a valid/ready request channel.
- Produces one registered product per accepted request on a single response channel, tagged with the requester ID.
- Sits between the multiply clients and the multiplier; it is the only block that drives the multiplier operands.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of requester ID; must equal ceil(log2(NUM_REQ)), minimum 1

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
- req_in1  input  8*NUM_REQ  packed multiplicand; requester i uses bits [8i+7:8i]
- req_in2  input  8*NUM_REQ  packed multiplier; requester i uses bits [8i+7:8i]
- resp_valid  output  1  response holds a valid product
- resp_ready  input  1  consumer accepts the response
- resp_id  output  ID_W  requester index of the response
- resp_data  output  16  product in1*in2, unsigned
- busy  output  1  response register occupied (equals resp_valid)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - resp_valid=0, resp_id=0, resp_data=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready is combinational and is forced to 0 while rst_n=0.
- State: single response register with two states.
  - EMPTY (resp_valid=0).
  - FULL (resp_valid=1).
- can_accept = !resp_valid || resp_ready. This allows back-to-back throughput of one product per cycle.
- Grant is combinational:
  - Search req_valid starting at index rr_ptr, upward with wrap-around modulo NUM_REQ.
  - The first asserted index g wins.
  - req_ready[g] = can_accept; all other req_ready bits = 0.
  - req_ready never depends on req_valid of the same requester other than via grant selection; it may depend on resp_ready.
- Accept occurs when req_valid[g] && req_ready[g]. At the next edge:
  - resp_data <= in1_g * in2_g, full 16-bit product, no truncation. Example: 255*255 = 16'hFE01.
  - resp_id <= g.
  - resp_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_REQ.
- Latency: exactly 1 cycle from accept to resp_valid.
- Drain without new accept (resp_valid && resp_ready, and no accept):
  - resp_valid <= 0.
  - resp_data and resp_id hold their last values.
- Drain and accept in the same cycle: the register loads the new product and resp_valid stays 1.
- Stall (resp_valid && !resp_ready):
  - resp_data and resp_id stay stable.
  - All req_ready = 0.
  - rr_ptr is unchanged.
- No request valid: rr_ptr is unchanged.
- Fairness:
  - A requester whose req_valid stays high is granted within NUM_REQ accepts.
  - When all requesters are continuously valid and resp_ready=1, grants cycle 0,1,2,3,0,...
- Requesters must hold req_valid and operands stable until accepted. The arbiter does not check this. An operand change before accept is simply used at accept time.
- Reset mid-operation: any pending response is discarded (resp_valid=0 next cycle) and rr_ptr returns to 0.
- Unused ID values (when NUM_REQ is not a power of two) are never produced.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with all req_valid=1 -> req_ready=0, resp_valid=0, resp_data=0, resp_id=0. First accept after release goes to requester 0.
- Single request: req 2 valid with in1=8'd13, in2=8'd11, resp_ready=1 -> req_ready=4'b0100 in the same cycle. Next cycle resp_valid=1, resp_id=2, resp_data=16'd143. The following cycle resp_valid=0 if no new request.
- Round-robin: all 4 valid continuously; operands req i: in1=i+1, in2=8'd10; resp_ready=1 -> responses every cycle with ids 0,1,2,3,0 and data 10,20,30,40,10.
- Back-pressure: after the first response, hold resp_ready=0 for 3 cycles with req 1 and req 3 valid -> resp_data/resp_id stable and req_ready=0 throughout. When resp_ready=1, req 1 is accepted that cycle and the next response is id 1.
- Width extremes: in1=8'hFF, in2=8'hFF -> 16'hFE01. in1=8'h80, in2=8'h02 -> 16'h0100. in1=0, in2=8'hFF -> 16'h0000.
- Reset mid-operation: response pending with resp_ready=0, then assert rst_n=0 for 1 cycle -> resp_valid=0 after the edge. The next accept, with req 1 and req 3 valid, goes to requester 1 (rr_ptr=0).
